// File: rtl/gusn_pkg.sv
// Shared fixed-point definitions and the weight memory controller state type.
package gusn_pkg;

  localparam int unsigned INT_W_DEFAULT  = 8;
  localparam int unsigned FRAC_W_DEFAULT = 8;

  function automatic int unsigned num_width(int unsigned int_w, int unsigned frac_w);
    return int_w + frac_w;
  endfunction

  localparam int unsigned NUM_W_DEFAULT = num_width(INT_W_DEFAULT, FRAC_W_DEFAULT);

  localparam logic signed [NUM_W_DEFAULT-1:0] MAX_VALUE_POS = {1'b0, {(NUM_W_DEFAULT-1){1'b1}}};
  localparam logic signed [NUM_W_DEFAULT-1:0] MAX_VALUE_NEG = {1'b1, {(NUM_W_DEFAULT-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    HOST_RD = 2'd2
  } wm_state_e;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth register chain with asynchronous active-low reset to zero.
module delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/weight_mem.sv
// Layer weight store with a free-running layer read pipeline, a host access port
// and a one-word-per-cycle zero-fill sweep.
module weight_mem
  import gusn_pkg::*;
#(
  parameter int unsigned INT_W      = 8,
  parameter int unsigned FRAC_W     = 8,
  parameter int unsigned RAM_ADDR_W = 10,
  parameter int unsigned RAM_DEPTH  = 1024,
  parameter int unsigned RAM_DELAY  = 2,
  localparam int unsigned NUM_W     = num_width(INT_W, FRAC_W)
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    ram_write,
  input  logic [RAM_ADDR_W-1:0]   ram_addr_write,
  input  logic signed [NUM_W-1:0] ram_data_write,
  input  logic [RAM_ADDR_W-1:0]   ram_addr_read,
  output logic signed [NUM_W-1:0] ram_data_read,
  input  logic                    layer_idle,
  input  logic                    host_valid,
  output logic                    host_ready,
  input  logic                    host_wr,
  input  logic [RAM_ADDR_W-1:0]   host_addr,
  input  logic signed [NUM_W-1:0] host_wdata,
  output logic                    host_rvalid,
  output logic signed [NUM_W-1:0] host_rdata,
  input  logic                    clear_start,
  output logic                    busy
);

  typedef logic [RAM_ADDR_W-1:0] addr_t;
  typedef logic [RAM_ADDR_W:0]   addr_ext_t;

  localparam addr_ext_t DEPTH_LIM = addr_ext_t'(RAM_DEPTH);
  localparam addr_t     CLR_LAST  = addr_t'(RAM_DEPTH - 1);

  logic signed [NUM_W-1:0] mem [RAM_DEPTH];

  wm_state_e state, state_nx;
  addr_t     clr_cnt, clr_nx;

  logic                    host_acc, host_wr_acc, host_rd_acc;
  logic                    wr_en;
  addr_t                   wr_addr;
  logic signed [NUM_W-1:0] wr_data;
  logic signed [NUM_W-1:0] layer_word, host_word, host_rdata_q;
  logic [NUM_W:0]          host_dl_in, host_dl_out;
  logic                    host_tag;

  function automatic logic in_range(addr_t a);
    return {1'b0, a} < DEPTH_LIM;
  endfunction

  // Gated by nreset so the handshake stays low while reset is held.
  assign host_ready  = nreset && (state == IDLE) && layer_idle && !clear_start && !ram_write;
  assign host_acc    = host_ready && host_valid;
  assign host_wr_acc = host_acc && host_wr;
  assign host_rd_acc = host_acc && !host_wr;
  assign busy        = (state != IDLE);

  // Host writes only get through when the layer is not writing, so they share its port.
  assign wr_en   = ram_write || host_wr_acc;
  assign wr_addr = ram_write ? ram_addr_write : host_addr;
  assign wr_data = ram_write ? ram_data_write : host_wdata;

  // Layer write is issued last so it overrides a clear of the same word.
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[clr_cnt] <= '0;
    if (wr_en && in_range(wr_addr)) mem[wr_addr] <= wr_data;
  end

  assign layer_word = in_range(ram_addr_read) ? mem[ram_addr_read] : '0;
  assign host_word  = (host_rd_acc && in_range(host_addr)) ? mem[host_addr] : '0;

  delay_line #(
    .WIDTH (NUM_W),
    .DEPTH (RAM_DELAY)
  ) u_layer_dl (
    .clk    (clk),
    .nreset (nreset),
    .din    (layer_word),
    .dout   (ram_data_read)
  );

  assign host_dl_in = {host_rd_acc, host_word};

  delay_line #(
    .WIDTH (NUM_W + 1),
    .DEPTH (RAM_DELAY)
  ) u_host_dl (
    .clk    (clk),
    .nreset (nreset),
    .din    (host_dl_in),
    .dout   (host_dl_out)
  );

  assign host_tag    = host_dl_out[NUM_W];
  assign host_rvalid = host_tag;
  assign host_rdata  = host_tag ? host_dl_out[NUM_W-1:0] : host_rdata_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state        <= IDLE;
      clr_cnt      <= '0;
      host_rdata_q <= '0;
    end else begin
      state   <= state_nx;
      clr_cnt <= clr_nx;
      if (host_tag) host_rdata_q <= host_dl_out[NUM_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    clr_nx   = clr_cnt;
    unique case (state)
      IDLE: begin
        if (layer_idle && clear_start) begin
          state_nx = CLEAR;
          clr_nx   = '0;
        end else if (host_rd_acc) begin
          state_nx = HOST_RD;
        end
      end
      CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nx = IDLE;
          clr_nx   = '0;
        end else begin
          clr_nx = clr_cnt + 1'b1;
        end
      end
      HOST_RD: begin
        if (host_tag) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_weight_mem.sv
// Scoreboard bench for weight_mem: a behavioural memory model predicts every layer
// read word and host read response; a negedge monitor pops and compares them.
module tb_weight_mem;

  localparam int DLY   = 2;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        nreset = 1'b1;
  logic        ram_write = 1'b0;
  logic [9:0]  ram_addr_write = '0;
  logic [15:0] ram_data_write = '0;
  logic [9:0]  ram_addr_read = '0;
  logic [15:0] ram_data_read;
  logic        layer_idle = 1'b1;
  logic        host_valid = 1'b0;
  logic        host_ready;
  logic        host_wr = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [15:0] host_wdata = '0;
  logic        host_rvalid;
  logic [15:0] host_rdata;
  logic        clear_start = 1'b0;
  logic        busy;

  weight_mem #(
    .INT_W      (8),
    .FRAC_W     (8),
    .RAM_ADDR_W (10),
    .RAM_DEPTH  (DEPTH),
    .RAM_DELAY  (DLY)
  ) dut (
    .clk            (clk),
    .nreset         (nreset),
    .ram_write      (ram_write),
    .ram_addr_write (ram_addr_write),
    .ram_data_write (ram_data_write),
    .ram_addr_read  (ram_addr_read),
    .ram_data_read  (ram_data_read),
    .layer_idle     (layer_idle),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_wr        (host_wr),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rvalid    (host_rvalid),
    .host_rdata     (host_rdata),
    .clear_start    (clear_start),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model
  logic [15:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_clearing = 0;
  int          m_clr_addr = 0;
  bit          m_hreading = 0;
  int          m_hdue = 0;
  int          cyc = 0;
  bit          acc_flag = 0;
  bit          run_mon = 0;
  logic [15:0] last_rdata = '0;

  typedef struct {
    int          due;
    bit          chk;
    logic [15:0] val;
  } exp_t;

  exp_t lq[$];
  exp_t hq[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit exp_ready();
    return nreset && !m_clearing && !m_hreading && layer_idle && !clear_start && !ram_write;
  endfunction

  function automatic void mwrite(int a, logic [15:0] d);
    m_mem[a]   = d;
    m_known[a] = 1'b1;
  endfunction

  always @(posedge clk) begin : model
    exp_t e;
    bit   rdy;
    bit   start_clr;
    if (nreset) begin
      acc_flag  = 0;
      rdy       = exp_ready();
      start_clr = !m_clearing && !m_hreading && layer_idle && clear_start;
      e.due = cyc + DLY;
      e.chk = m_known[ram_addr_read];
      e.val = m_mem[ram_addr_read];
      lq.push_back(e);
      if (m_clearing) begin
        mwrite(m_clr_addr, 16'h0000);
        m_clr_addr++;
        if (m_clr_addr == DEPTH) m_clearing = 0;
      end
      if (m_hreading && cyc == m_hdue) m_hreading = 0;
      if (rdy && host_valid) begin
        acc_flag = 1;
        if (host_wr) mwrite(int'(host_addr), host_wdata);
        else begin
          e.due = cyc + DLY;
          e.chk = m_known[host_addr];
          e.val = m_mem[host_addr];
          hq.push_back(e);
          m_hreading = 1;
          m_hdue     = cyc + DLY;
        end
      end
      if (ram_write) mwrite(int'(ram_addr_write), ram_data_write);
      if (start_clr) begin
        m_clearing = 1;
        m_clr_addr = 0;
      end
      cyc++;
    end
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (nreset && run_mon) begin
      check("host_ready", host_ready, exp_ready());
      check("busy", busy, m_clearing || m_hreading);
      if (lq.size() != 0 && lq[0].due == cyc) begin
        e = lq.pop_front();
        if (e.chk) check("layer_rdata", ram_data_read, e.val);
      end
      if (host_rvalid) begin
        if (hq.size() == 0) check("host_rvalid_unexpected", host_rvalid, 0);
        else begin
          e = hq.pop_front();
          check("host_rvalid_latency", cyc, e.due);
          if (e.chk) check("host_rdata", host_rdata, e.val);
          last_rdata = e.val;
        end
      end else begin
        if (hq.size() != 0 && hq[0].due < cyc) begin
          e = hq.pop_front();
          check("host_rvalid_missing", 0, 1);
        end
        check("host_rdata_hold", host_rdata, last_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    lq.delete();
    hq.delete();
    m_clearing = 0;
    m_hreading = 0;
    m_clr_addr = 0;
    acc_flag   = 0;
    last_rdata = '0;
    ram_write = 0; host_valid = 0; clear_start = 0; layer_idle = 1;
    #1;
    check("rst_ram_data_read", ram_data_read, 0);
    check("rst_host_ready", host_ready, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
  endtask

  task automatic host_op(bit wr, logic [9:0] a, logic [15:0] d, output int waited);
    int n;
    host_valid = 1; host_wr = wr; host_addr = a; host_wdata = d;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!acc_flag && waited < 3000);
    host_valid = 0;
    check("host_accept", acc_flag, 1);
    if (!wr) begin
      n = 0;
      while (m_hreading && n < 100) begin
        tick();
        n++;
      end
      check("host_read_done", m_hreading, 0);
    end
  endtask

  task automatic layer_write(logic [9:0] a, logic [15:0] d);
    ram_write = 1; ram_addr_write = a; ram_data_write = d;
    tick();
    ram_write = 0;
  endtask

  task automatic layer_read(logic [9:0] a);
    ram_addr_read = a;
    tick();
  endtask

  initial begin : stim
    int w;
    int n;
    int same_addr;
    #2;
    do_reset();
    run_mon = 1;

    layer_write(10'd5, 16'h0123);
    layer_read(10'd5);
    repeat (2) tick();

    layer_write(10'd9, 16'h0001);
    ram_write = 1; ram_addr_write = 10'd9; ram_data_write = 16'h7FFF; ram_addr_read = 10'd9;
    tick();
    ram_write = 0;
    tick();
    repeat (2) tick();

    // Zero-fill with layer traffic running alongside it
    same_addr = -1;
    clear_start = 1;
    tick();
    clear_start = 0;
    n = 0;
    while (busy && n < 2000) begin
      ram_addr_read  = 10'($urandom_range(DEPTH - 1));
      ram_addr_write = 10'($urandom_range(DEPTH - 1));
      ram_data_write = 16'($urandom);
      ram_write      = ($urandom_range(3) == 0);
      if (n == 100) begin
        ram_write = 1;
        ram_addr_write = 10'(m_clr_addr);
        same_addr = m_clr_addr;
      end
      if (ram_addr_write == 10'd0 || ram_addr_write == 10'd511 || ram_addr_write == 10'd1023)
        ram_write = 0;
      tick();
      n++;
    end
    ram_write = 0;
    check("clear_busy_cycles", n, DEPTH);
    if (same_addr >= 0) layer_read(10'(same_addr));
    host_op(0, 10'd0, '0, w);
    host_op(0, 10'd511, '0, w);
    host_op(0, 10'd1023, '0, w);

    layer_idle = 0;
    host_valid = 1; host_wr = 1; host_addr = 10'd77; host_wdata = 16'h5A5A;
    repeat (5) tick();
    check("host_blocked_layer_busy", acc_flag, 0);
    layer_idle = 1;
    host_op(1, 10'd77, 16'h5A5A, w);
    check("host_accept_after_idle", w, 1);
    host_op(0, 10'd77, '0, w);

    clear_start = 1;
    host_valid = 1; host_wr = 0; host_addr = 10'd77;
    tick();
    clear_start = 0;
    check("clear_beats_host", acc_flag, 0);
    host_op(0, 10'd77, '0, w);
    check("host_wait_for_clear", w, DEPTH + 1);

    for (int i = 0; i < 1500; i++) begin
      ram_write      = ($urandom_range(3) == 0);
      ram_addr_write = 10'($urandom_range(DEPTH - 1));
      ram_data_write = 16'($urandom);
      ram_addr_read  = 10'($urandom_range(DEPTH - 1));
      layer_idle     = ($urandom_range(7) != 0);
      if (!host_valid || acc_flag) begin
        host_valid = ($urandom_range(2) == 0);
        host_wr    = 1'($urandom_range(1));
        host_addr  = 10'($urandom_range(DEPTH - 1));
        host_wdata = 16'($urandom);
      end
      tick();
    end
    ram_write = 0; host_valid = 0; layer_idle = 1;
    n = 0;
    while ((m_hreading || m_clearing) && n < 100) begin
      tick();
      n++;
    end
    check("random_phase_settle", m_hreading, 0);

    layer_write(10'd299, 16'h2990);
    layer_write(10'd300, 16'h3000);
    layer_write(10'd301, 16'h3010);
    clear_start = 1;
    tick();
    clear_start = 0;
    n = 0;
    while (m_clr_addr != 300 && n < 2000) begin
      tick();
      n++;
    end
    check("reset_point_reached", m_clr_addr, 300);
    do_reset();
    layer_read(10'd299);
    layer_read(10'd300);
    layer_read(10'd301);
    host_op(0, 10'd301, '0, w);
    repeat (5) tick();

    check("host_queue_drained", hq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/weight_mem.md
WEIGHT_MEM -- requirements
Module: weight_mem

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  INT_W  8  integer bits of fixed-point word.
  FRAC_W  8  fraction bits; NUM_W = INT_W + FRAC_W.
  RAM_ADDR_W  10  address width.
  RAM_DEPTH  1024  words implemented (at most 2**RAM_ADDR_W).
  RAM_DELAY  2  read latency in cycles, at least 1.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge.
  nreset  in  1  reset, asynchronous, active-low.
  ram_write  in  1  layer write strobe.
  ram_addr_write  in  RAM_ADDR_W  layer write address.
  ram_data_write  in  NUM_W signed  layer write data.
  ram_addr_read  in  RAM_ADDR_W  layer read address, sampled every cycle.
  ram_data_read  out  NUM_W signed  layer read data, RAM_DELAY cycles after its address.
  layer_idle  in  1  layer ready_out; host and clear may run only while high.
  host_valid  in  1  host request.
  host_ready  out  1  host request accepted this cycle.
  host_wr  in  1  1 = write, 0 = read.
  host_addr  in  RAM_ADDR_W  host address.
  host_wdata  in  NUM_W signed  host write data.
  host_rvalid  out  1  one-cycle pulse, host read data valid.
  host_rdata  out  NUM_W signed  host read data.
  clear_start  in  1  request to zero-fill the whole memory.
  busy  out  1  clear sweep or host read in flight.

Function
REQ-003 SHALL store RAM_DEPTH words of NUM_W bits; addresses at or above RAM_DEPTH SHALL be ignored on write and SHALL return 0 on read.
REQ-004 Layer read SHALL be a RAM_DELAY-deep pipeline: ram_data_read at cycle t+RAM_DELAY = mem[ram_addr_read at t]. It SHALL run every cycle regardless of state.
REQ-005 Layer write SHALL commit at the clock edge where ram_write=1.
REQ-006 A layer read and write to the same address in the same cycle SHALL be read-first (old data); the new data SHALL be visible from the next cycle.
REQ-007 FSM states: IDLE, CLEAR, HOST_RD.
REQ-008 IDLE -> CLEAR when clear_start=1 and layer_idle=1. clear_start takes priority over host_valid in the same cycle.
REQ-009 CLEAR SHALL write 0 to one address per cycle, 0 to RAM_DEPTH-1, then return to IDLE, for RAM_DEPTH cycles total. busy=1 throughout.
REQ-010 host_ready SHALL be 1 only in IDLE, with layer_idle=1, clear_start=0 and ram_write=0.
REQ-011 An accepted host write SHALL commit at the same edge and keep the state IDLE.
REQ-012 An accepted host read SHALL go to HOST_RD. host_rvalid SHALL pulse exactly RAM_DELAY cycles later with host_rdata = mem[host_addr], after which the state SHALL return to IDLE.
REQ-013 During CLEAR and HOST_RD, layer writes SHALL still be honoured. A layer write SHALL win over a clear write to the same address in the same cycle.
REQ-014 layer_idle falling mid-CLEAR or mid-HOST_RD SHALL NOT abort the operation.
REQ-015 host_rdata SHALL hold its last value until the next host_rvalid.

Reset
REQ-016 nreset low SHALL asynchronously set: state IDLE, ram_data_read 0, all pipeline stages 0, host_ready 0, host_rvalid 0, host_rdata 0, busy 0, clear counter 0.
REQ-017 Memory contents SHALL NOT be reset. A reset during CLEAR leaves a partially cleared memory, and the host must reissue clear_start.

Structure
REQ-018 NUM_W derivation and the saturation constants MAX_VALUE_POS / MAX_VALUE_NEG SHALL live in shared package gusn_pkg.
REQ-019 The RAM_DELAY register chain SHALL be one sub-module, delay_line (parameters WIDTH and DEPTH, async active-low reset to 0), used for the layer read data and for the host read-valid tag.
REQ-020 The storage array SHALL be inferable as block RAM plus output registers.

Verification
REQ-021 Reset, then layer write 0x0123 to addr 5, then read addr 5 -> ram_data_read = 0x0123 exactly 2 cycles after the address (RAM_DELAY=2).
REQ-022 Same cycle: write 0x7FFF to addr 9 (old value 0x0001) and read addr 9 -> 0x0001 returned; read one cycle later -> 0x7FFF.
REQ-023 layer_idle=1, clear_start pulse -> busy=1 for 1024 cycles. Afterwards host reads of addrs 0, 511, 1023 each return 0x0000 with a single host_rvalid.
REQ-024 host_valid write while layer_idle=0 -> host_ready stays 0. layer_idle rises -> accepted next cycle, and readback matches.
REQ-025 clear_start and host_valid in the same cycle -> clear wins, and host_ready=0 until clear ends.
REQ-026 nreset asserted mid-CLEAR at addr 300 -> all outputs 0 immediately, addr 299 = 0, addr 301 keeps its old data.
